// File: rtl/vga_rx.sv
// VGA timing receiver: registers incoming sync/RGB, recovers the sample and
// line position from the sync trailing edges, measures line/frame lengths,
// locks to the expected mode and emits X/Y/DE/PIXEL two samples after capture.
module vga_rx #(
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL_EXP = 800,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL_EXP = 525,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        HS,
    input  logic        VS,
    input  logic [3:0]  RED,
    input  logic [3:0]  GREEN,
    input  logic [3:0]  BLUE,
    output logic [9:0]  X,
    output logic [9:0]  Y,
    output logic        DE,
    output logic [11:0] PIXEL,
    output logic        FRAME_START,
    output logic        LOCKED,
    output logic [10:0] H_TOTAL,
    output logic [10:0] V_TOTAL
);

    localparam logic [10:0] H_BEG  = 11'(H_BACK);
    localparam logic [10:0] H_END  = 11'(H_BACK + H_ACTIVE);
    localparam logic [10:0] V_BEG  = 11'(V_BACK);
    localparam logic [10:0] V_END  = 11'(V_BACK + V_ACTIVE);
    localparam logic [10:0] H_EXP  = 11'(H_TOTAL_EXP);
    localparam logic [10:0] V_EXP  = 11'(V_TOTAL_EXP);
    localparam logic [10:0] CNT_MAX = 11'h7ff;
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_t;

    // Increment that sticks at the 11-bit ceiling instead of wrapping.
    function automatic logic [10:0] sat_inc(input logic [10:0] a);
        return (a == CNT_MAX) ? CNT_MAX : a + 11'd1;
    endfunction

    logic        hs_p0, vs_p0, hs_p1, vs_p1;
    logic [11:0] rgb_p0, rgb_p1;
    logic [10:0] h, v;
    logic        line_err;
    state_t      state;
    logic [3:0]  good_cnt;

    logic        hs_trail, vs_trail;
    logic [10:0] h_len, v_len, h_next;
    logic        line_bad, frame_good, sat_now, vld_p1;

    // Stage p0/p1: sync lines; reset to the idle level so no phantom edge appears after reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_p0 <= ~SYNC_POL;
            vs_p0 <= ~SYNC_POL;
            hs_p1 <= ~SYNC_POL;
            vs_p1 <= ~SYNC_POL;
        end else begin
            hs_p0 <= HS;
            vs_p0 <= VS;
            hs_p1 <= hs_p0;
            vs_p1 <= vs_p0;
        end
    end

    // Stage p0/p1: pixel data follows the sync pipeline without reset.
    always_ff @(posedge CLK) begin
        rgb_p0 <= {RED, GREEN, BLUE};
        rgb_p1 <= rgb_p0;
    end

    // Edge detection, measured lengths and the per-frame verdict for the sample now in p0.
    always_comb begin
        hs_trail   = (hs_p1 == SYNC_POL) && (hs_p0 != SYNC_POL);
        vs_trail   = (vs_p1 == SYNC_POL) && (vs_p0 != SYNC_POL);
        h_len      = sat_inc(h);
        v_len      = sat_inc(v);
        line_bad   = hs_trail && (h_len != H_EXP);
        frame_good = !line_err && !line_bad && (v_len == V_EXP);
        h_next     = hs_trail ? 11'd0 : h_len;
        sat_now    = (h_next == CNT_MAX);
        vld_p1     = (state == ST_LOCKED) && (h >= H_BEG) && (h < H_END) &&
                     (v >= V_BEG) && (v < V_END);
    end

    // Position counters, length measurement and the line-error flag for the current frame.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h        <= '0;
            v        <= '0;
            H_TOTAL  <= '0;
            V_TOTAL  <= '0;
            line_err <= 1'b0;
        end else begin
            h <= h_next;
            if (vs_trail)
                v <= '0;
            else if (hs_trail)
                v <= v_len;
            if (hs_trail)
                H_TOTAL <= h_len;
            if (vs_trail)
                V_TOTAL <= v_len;
            line_err <= vs_trail ? 1'b0 : (line_err | line_bad);
        end
    end

    // Lock state machine, evaluated once per frame; a dead HS line forces a restart.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            good_cnt <= '0;
        end else if (sat_now) begin
            state    <= ST_IDLE;
            good_cnt <= '0;
        end else if (vs_trail) begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_ACQUIRE;
                    good_cnt <= '0;
                end
                ST_ACQUIRE: begin
                    if (frame_good) begin
                        good_cnt <= good_cnt + 4'd1;
                        if ((good_cnt + 4'd1) == LOCK_N)
                            state <= ST_LOCKED;
                    end else begin
                        good_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good) begin
                        state    <= ST_ACQUIRE;
                        good_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    good_cnt <= '0;
                end
            endcase
        end
    end

    // Stage p2: registered outputs; coordinates and pixel hold outside the active window.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            X           <= '0;
            Y           <= '0;
            DE          <= 1'b0;
            PIXEL       <= '0;
            FRAME_START <= 1'b0;
            LOCKED      <= 1'b0;
        end else begin
            LOCKED      <= (state == ST_LOCKED);
            DE          <= vld_p1;
            FRAME_START <= vld_p1 && (h == H_BEG) && (v == V_BEG);
            if (vld_p1) begin
                X     <= 10'(h - H_BEG);
                Y     <= 10'(v - V_BEG);
                PIXEL <= rgb_p1;
            end
        end
    end

endmodule
